// File: rtl/pi_nib_pkg.sv
// rtl/pi_nib_pkg.sv - shared widths and FSM encoding for the Pi nibble receiver
package pi_nib_pkg;

  localparam int NIB_W  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } nib_state_t;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - single-bit multi-flop synchronizer for an asynchronous Pi line
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_q;

  // No reset: the chain flushes while reset is held, and a reset value would fake an edge.
  always_ff @(posedge i_clk) begin
    r_q <= {r_q[STAGES-2:0], i_d};
  end

  assign o_q = r_q[STAGES-1];

endmodule

// File: rtl/pi_nib_rx.sv
// rtl/pi_nib_rx.sv - Pi nibble/latch receiver driving one-hot shift/latch strobes
// Optional PI_NIB_GLITCH_FILTER_EN: edges need 2 stable synchronized samples.
module pi_nib_rx
  import pi_nib_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NREG        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pi_clk,
  input  logic [0:NIB_W-1]  pi_din,
  input  logic              pi_le,
  input  logic [0:1]        pi_sel,
  input  logic              err_clr,
  output logic [0:NREG-1]   sel,
  output logic              le,
  output logic [0:NIB_W-1]  nib,
  output logic [0:BYTE_W-1] byte_cnt,
  output logic              err_frame,
  output logic              err_ovr
);

  logic [7:0]       w_raw;
  logic [7:0]       w_sy;
  logic [1:0]       w_lvl;
  logic [1:0]       w_psel;
  logic [0:NIB_W-1] w_din;

  assign w_raw = {pi_clk, pi_le, pi_sel, pi_din};

  for (genvar gi = 0; gi < 8; gi++) begin : g_sync
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .i_clk (clk),
      .i_d   (w_raw[gi]),
      .o_q   (w_sy[gi])
    );
  end

  assign w_lvl  = w_sy[7:6];
  assign w_psel = w_sy[5:4];
  assign w_din  = w_sy[3:0];

  logic [1:0] r_prev;
  logic [1:0] w_filt;
  logic [1:0] w_edge;

`ifdef PI_NIB_GLITCH_FILTER_EN
  logic [1:0] r_samp;

  always_ff @(posedge clk) begin
    r_samp <= w_lvl;
  end

  always_comb begin
    w_filt = r_prev;
    for (int i = 0; i < 2; i++) begin
      if (w_lvl[i] == r_samp[i]) w_filt[i] = w_lvl[i];
    end
  end
`else
  assign w_filt = w_lvl;
`endif

  // Reset to 1 so a line held high through reset must fall before it can strobe.
  always_ff @(posedge clk) begin
    if (reset) r_prev <= 2'b11;
    else       r_prev <= w_filt;
  end

  assign w_edge = w_filt & ~r_prev;

  logic             r_pnd_v, r_pnd_le;
  logic [1:0]       r_pnd_sel;
  logic [0:NIB_W-1] r_pnd_nib;
  logic             w_nxt_pv, w_nxt_ple;
  logic [1:0]       w_nxt_psel;
  logic [0:NIB_W-1] w_nxt_pnib;
  logic             w_iss_v, w_iss_le;
  logic [1:0]       w_iss_sel;
  logic [0:NIB_W-1] w_iss_nib;
  logic [0:NREG-1]  w_sel_oh;
  nib_state_t       r_state, w_state_nxt;
  logic             w_set_ovr, w_set_frm;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_iss_v     = 1'b0;
    w_iss_le    = 1'b0;
    w_iss_sel   = w_psel;
    w_iss_nib   = w_din;
    w_nxt_pv    = 1'b0;
    w_nxt_ple   = r_pnd_le;
    w_nxt_psel  = r_pnd_sel;
    w_nxt_pnib  = r_pnd_nib;
    w_state_nxt = r_state;
    w_set_ovr   = 1'b0;
    w_set_frm   = 1'b0;
    w_sel_oh    = '0;

    // One strobe per cycle, oldest first; the younger event waits one cycle.
    if (r_pnd_v) begin
      w_iss_v   = 1'b1;
      w_iss_le  = r_pnd_le;
      w_iss_sel = r_pnd_sel;
      w_iss_nib = r_pnd_nib;
      if (w_edge[1] || w_edge[0]) begin
        w_nxt_pv   = 1'b1;
        w_nxt_ple  = ~w_edge[1];
        w_nxt_psel = w_psel;
        w_nxt_pnib = w_din;
      end
    end else if (w_edge[1]) begin
      w_iss_v = 1'b1;
      if (w_edge[0]) begin
        w_nxt_pv   = 1'b1;
        w_nxt_ple  = 1'b1;
        w_nxt_psel = w_psel;
        w_nxt_pnib = w_din;
      end
    end else if (w_edge[0]) begin
      w_iss_v  = 1'b1;
      w_iss_le = 1'b1;
    end

    if (w_iss_v) begin
      if (w_iss_le) begin
        w_state_nxt = ST_EMPTY;
        w_set_frm   = (r_state != ST_FULL);
      end else begin
        case (r_state)
          ST_EMPTY: w_state_nxt = ST_HALF;
          ST_HALF:  w_state_nxt = ST_FULL;
          default: begin
            w_state_nxt = ST_FULL;
            w_set_ovr   = 1'b1;
          end
        endcase
      end
      for (int i = 0; i < NREG; i++) begin
        if (int'(w_iss_sel) == i) w_sel_oh[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pnd_v   <= 1'b0;
      r_pnd_le  <= 1'b0;
      r_pnd_sel <= '0;
      r_pnd_nib <= '0;
      sel       <= '0;
      le        <= 1'b0;
      nib       <= '0;
      byte_cnt  <= '0;
      err_frame <= 1'b0;
      err_ovr   <= 1'b0;
    end else begin
      r_pnd_v   <= w_nxt_pv;
      r_pnd_le  <= w_nxt_ple;
      r_pnd_sel <= w_nxt_psel;
      r_pnd_nib <= w_nxt_pnib;
      sel       <= w_sel_oh;
      le        <= w_iss_v & w_iss_le & (|w_sel_oh);
      if (w_iss_v && !w_iss_le) nib <= w_iss_nib;
      if (w_iss_v && w_iss_le) byte_cnt <= byte_cnt + BYTE_W'(1);
      err_frame <= w_set_frm | (err_frame & ~err_clr);
      err_ovr   <= w_set_ovr | (err_ovr & ~err_clr);
    end
  end

endmodule

// File: doc/pi_nib_rx.md
PI_NIB_RX -- requirements
Module: pi_nib_rx

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth for all Pi-side inputs (legal range 2..4).
REQ-002 The module SHALL have parameter NREG, default 4, meaning the number of downstream shift registers addressed by one-hot select.
REQ-003 clk  input  1  is the single system clock; all logic is on its rising edge.
REQ-004 reset  input  1  is the synchronous, active-high reset.
REQ-005 pi_clk  input  1  is the asynchronous Pi nibble strobe; a rising edge means "pi_din valid".
REQ-006 pi_din  input  [0:3]  is the asynchronous nibble from the Pi, MSB at bit 0.
REQ-007 pi_le  input  1  is the asynchronous Pi latch request; a rising edge means "byte complete".
REQ-008 pi_sel  input  [0:1]  is the asynchronous target register index.
REQ-009 err_clr  input  1  clears the sticky error flags.
REQ-010 sel  output  [0:NREG-1]  is the one-hot, single-cycle select to the downstream shift stage.
REQ-011 le  output  1  is qualified by sel: 1 = latch strobe, 0 = shift strobe.
REQ-012 nib  output  [0:3]  is the nibble presented with a shift strobe, held until the next shift strobe.
REQ-013 byte_cnt  output  [0:7]  counts completed latches.
REQ-014 err_frame  output  1  is a sticky flag: a latch occurred with a nibble count other than 2.
REQ-015 err_ovr  output  1  is a sticky flag: a third or later nibble arrived before a latch.

Function
REQ-016 Every Pi input SHALL pass through SYNC_STAGES flops before use; pi_din and pi_sel SHALL be sampled from the same synchronized stage as pi_clk.
REQ-017 A synchronized 0->1 transition of pi_clk SHALL produce exactly one cycle with sel[pi_sel]=1 and le=0, with nib loaded in the same cycle; latency from the input edge is SYNC_STAGES+1 cycles.
REQ-018 A synchronized 0->1 transition of pi_le SHALL produce exactly one cycle with sel[pi_sel]=1 and le=1, with the same latency.
REQ-019 Outside strobe cycles, sel SHALL be all-zero and le SHALL be 0.
REQ-020 If pi_clk and pi_le edges are detected in the same cycle, the shift SHALL be issued first and the latch in the next cycle, using a one-deep pending flag.
REQ-021 If a new edge arrives while a latch is pending, the pending latch SHALL issue first and the new edge SHALL issue in the following cycle; no edge is dropped.
REQ-022 The FSM states SHALL be EMPTY (0 nibbles), HALF (1), FULL (2 or more): shift moves EMPTY->HALF->FULL, FULL->FULL, and any latch returns to EMPTY.
REQ-023 A shift in FULL SHALL set err_ovr; the shift strobe is still issued.
REQ-024 A latch in EMPTY or HALF SHALL set err_frame; the latch strobe is still issued.
REQ-025 byte_cnt SHALL increment by 1 on every latch strobe and wrap 255->0.
REQ-026 err_clr SHALL clear both flags; if err_clr coincides with a new error, the set takes priority.

Reset
REQ-027 reset SHALL clear all outputs, byte_cnt, the error flags and the pending flag, and force the FSM to EMPTY.
REQ-028 After reset, each edge detector SHALL be disarmed until it sees a synchronized 0, so a Pi line held high through reset produces no strobe.
REQ-029 A reset asserted mid-byte SHALL discard the partial nibble count and any pending latch without emitting a strobe.

Configuration
REQ-030 With PI_NIB_GLITCH_FILTER_EN defined, an edge SHALL be accepted only after the new level is stable for 2 consecutive synchronized samples, adding 1 cycle of latency (total SYNC_STAGES+2).
REQ-031 Without PI_NIB_GLITCH_FILTER_EN, edges SHALL be accepted on a single synchronized sample (latency SYNC_STAGES+1), and no filter flops are instantiated.

Structure
REQ-032 The FSM state encoding, the nibble width (4) and the byte width (8) SHALL live in the shared package pi_nib_pkg.
REQ-033 The synchronizer SHALL be the sub-module sync_bit, instantiated once per Pi input bit.

Verification
REQ-034 Reset, then pi_sel=2, nibbles 0xA and 0x5, then pi_le -> two shift strobes with sel=0010 and nib=A then 5, one latch strobe, byte_cnt=1, no errors.
REQ-035 pi_clk and pi_le rise in the same clk cycle -> shift strobe in cycle N and latch strobe in cycle N+1.
REQ-036 Three nibbles then a latch -> err_ovr=1; a latch after one nibble -> err_frame=1; err_clr -> both flags 0.
REQ-037 Issue 256 complete bytes -> byte_cnt=0 after wrapping from 255.
REQ-038 pi_clk held high across reset release -> no strobe until the line falls and rises again.
REQ-039 With PI_NIB_GLITCH_FILTER_EN, a 1-cycle pi_clk pulse -> no strobe; a 3-cycle pulse -> one strobe at latency SYNC_STAGES+2.
